// File: rtl/esc_array_if.sv
// esc_array_if: speed-command / motor-output bundle for the ESC array.
//
// Signals:
//   spd        packed speed words, channel i at [i*SPD_W +: SPD_W]
//   spd_vld    one-cycle strobe, capture spd into the shadow registers
//   motors_off level, forces every channel to speed 0 at the next frame
//   pwm        per-channel PWM outputs
//   frame_strt one-cycle pulse aligned with the start of every PWM frame
//   stale      high while the stale-command failsafe is active
//
// Modports: master = flight controller side, slave = esc_array.
interface esc_array_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SPD_W  = 11
);
    logic [NUM_CH*SPD_W-1:0] spd;
    logic                    spd_vld;
    logic                    motors_off;
    logic [NUM_CH-1:0]       pwm;
    logic                    frame_strt;
    logic                    stale;

    modport master (
        output spd, spd_vld, motors_off,
        input  pwm, frame_strt, stale
    );

    modport slave (
        input  spd, spd_vld, motors_off,
        output pwm, frame_strt, stale
    );
endinterface

// File: rtl/esc_array.sv
// esc_array: N-channel ESC/PWM generator with a common frame counter.
//
// Each channel produces one pulse per frame of MIN_PULSE + active*SCALE clocks.
// Speed words are captured (saturated at MAX_SPD) into shadow registers on spd_vld
// and moved into the active registers only at the last cycle of a frame, so a pulse
// in flight is never disturbed. A stale-command failsafe zeroes all speeds after
// STALE_FRAMES frame boundaries without a spd_vld.
//
// Optional feature: define SLEW_LIMIT_EN to limit the per-frame change of each
// active speed to MAX_STEP (motors_off / stale still force 0 immediately).
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  esc_array_if.slave (spd, spd_vld, motors_off in; pwm, frame_strt, stale out)
module esc_array #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned SPD_W        = 11,
    parameter int unsigned PERIOD       = 1000000,
    parameter int unsigned MIN_PULSE    = 50000,
    parameter int unsigned SCALE        = 25,
    parameter int unsigned MAX_SPD      = 2000,
    parameter int unsigned STALE_FRAMES = 8,
    parameter int unsigned MAX_STEP     = 64
) (
    input logic        clk,
    input logic        rst,
    esc_array_if.slave bus
);
    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned MAX_W = (SPD_W > CNT_W) ? SPD_W : CNT_W;
    // Full-precision pulse width, never truncated.
    localparam int unsigned WID_W = MAX_W + $clog2(SCALE) + 1;
    localparam int unsigned STC_W = $clog2(STALE_FRAMES + 1);

    if (MAX_SPD > (2 ** SPD_W) - 1) begin : g_bad_max_spd
        $error("MAX_SPD does not fit in SPD_W bits");
    end
    if (MAX_STEP == 0) begin : g_bad_max_step
        $error("MAX_STEP must be non-zero");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [STC_W-1:0] stale_cnt_q, stale_cnt_d;
    logic             stale_q, stale_d;
    logic             frame_strt_q;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [SPD_W-1:0] shadow_q [NUM_CH];
    logic [SPD_W-1:0] shadow_d [NUM_CH];
    logic [SPD_W-1:0] active_q [NUM_CH];
    logic [SPD_W-1:0] active_d [NUM_CH];
    logic [WID_W-1:0] width [NUM_CH];
    logic             boundary;
    logic             force_zero;

    assign boundary = (cnt_q == CNT_W'(PERIOD - 1));

    always_comb begin
        logic [SPD_W-1:0] cap;
        logic [SPD_W-1:0] tgt;
`ifdef SLEW_LIMIT_EN
        logic signed [SPD_W:0] diff;
        logic signed [SPD_W:0] step;
`endif
        cnt_d       = boundary ? '0 : cnt_q + 1'b1;
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;

        // stale_cnt = frame boundaries passed since the last spd_vld.
        if (bus.spd_vld) begin
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else if (boundary) begin
            if (stale_cnt_q < STC_W'(STALE_FRAMES)) begin
                stale_cnt_d = stale_cnt_q + 1'b1;
            end
            if (stale_cnt_d == STC_W'(STALE_FRAMES)) begin
                stale_d = 1'b1;
            end
        end

        // The failsafe decision at a boundary uses the stale value taking effect on
        // this edge, so a trip or a coincident spd_vld acts on the very next frame.
        force_zero = bus.motors_off | stale_d;

        for (int i = 0; i < NUM_CH; i++) begin
            cap = bus.spd[i*SPD_W +: SPD_W];
            if (cap > SPD_W'(MAX_SPD)) begin
                cap = SPD_W'(MAX_SPD);
            end
            shadow_d[i] = bus.spd_vld ? cap : shadow_q[i];
            tgt         = force_zero ? '0 : shadow_d[i];
`ifdef SLEW_LIMIT_EN
            diff = $signed({1'b0, tgt}) - $signed({1'b0, active_q[i]});
            if (diff > $signed((SPD_W + 1)'(MAX_STEP))) begin
                step = $signed((SPD_W + 1)'(MAX_STEP));
            end else if (diff < -$signed((SPD_W + 1)'(MAX_STEP))) begin
                step = -$signed((SPD_W + 1)'(MAX_STEP));
            end else begin
                step = diff;
            end
            if (!boundary) begin
                active_d[i] = active_q[i];
            end else if (force_zero) begin
                active_d[i] = '0;
            end else begin
                active_d[i] = active_q[i] + step[SPD_W-1:0];
            end
`else
            active_d[i] = boundary ? tgt : active_q[i];
`endif
            width[i] = WID_W'(MIN_PULSE) + WID_W'(active_q[i]) * WID_W'(SCALE);
            pwm_d[i] = (WID_W'(cnt_q) < width[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            stale_cnt_q  <= '0;
            stale_q      <= 1'b1;
            frame_strt_q <= 1'b0;
            pwm_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            stale_cnt_q  <= stale_cnt_d;
            stale_q      <= stale_d;
            // Registered from cnt == 0 so it lines up with the first pwm high cycle.
            frame_strt_q <= (cnt_q == '0);
            pwm_q        <= pwm_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.frame_strt = frame_strt_q;
    assign bus.stale      = stale_q;
endmodule
